// File: rtl/rv_pkg.sv
// Shared RV64 decode constants, NOP encoding and the mul/div sequencer state type.
// Also holds the small decode helpers that the ID-stage control blocks use.
package rv_pkg;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP32   = 7'b0111011;
   localparam logic [6:0] OPIMM  = 7'b0010011;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // addi x0, x0, 0
   localparam logic [6:0]  NOP_OPCODE = OPIMM;
   localparam logic [4:0]  NOP_RD     = 5'd0;
   localparam logic [4:0]  NOP_RS1    = 5'd0;
   localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_PEND = 2'd2
   } md_state_t;

   function automatic logic uses_rs1(input logic [6:0] opcode);
      return !(opcode == LUI || opcode == AUIPC || opcode == JAL);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opcode);
      return (opcode == OP || opcode == OP32 || opcode == STORE || opcode == BRANCH);
   endfunction

   function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] func7);
      return (opcode == OP || opcode == OP32) && (func7 == FUNCT7_MULDIV);
   endfunction

endpackage

// File: rtl/id_hazard_ctrl_scoreboard.sv
// Per-register pending-write vector for mul/div destinations, with source/dest lookups.
// x0 is never marked busy, so its lookups always read clear.
module id_scoreboard (
   input  logic        clk,
   input  logic        rst,
   input  logic        set_en,
   input  logic [4:0]  set_idx,
   input  logic        clr_en,
   input  logic [4:0]  clr_idx,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [4:0]  rd,
   output logic [31:0] busy,
   output logic        rs1_busy,
   output logic        rs2_busy,
   output logic        rd_busy
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (clr_en)
            busy[clr_idx] <= 1'b0;
         if (set_en && set_idx != 5'd0)
            busy[set_idx] <= 1'b1;
      end
   end

   assign rs1_busy = (rs1 != 5'd0) && busy[rs1];
   assign rs2_busy = (rs2 != 5'd0) && busy[rs2];
   assign rd_busy  = (rd  != 5'd0) && busy[rd];

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: load-use / scoreboard / structural stalls, redirects,
// mul/div launch sequencing and RF write-port arbitration between WB and the MD result.
module id_hazard_ctrl
   import rv_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [6:0]       id_opcode,
   input  logic [6:0]       id_func7,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             ex_valid,
   input  logic [6:0]       ex_opcode,
   input  logic [4:0]       ex_rd,
   input  logic             br_taken,
   input  logic             wb_wen,
   input  logic             md_done,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             md_start,
   output logic             md_wb_grant,
   output logic [4:0]       md_rd,
   output logic [31:0]      sb_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   md_state_t state, state_nx;
   logic use1, use2, md_op;
   logic rs1_busy, rs2_busy, rd_busy;
   logic load_use, raw, waw, structural, stall;

   assign use1  = uses_rs1(id_opcode);
   assign use2  = uses_rs2(id_opcode);
   assign md_op = is_muldiv(id_opcode, id_func7);

   id_scoreboard u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_en   (md_start),
      .set_idx  (id_rd),
      .clr_en   (md_wb_grant),
      .clr_idx  (md_rd),
      .rs1      (id_rs1),
      .rs2      (id_rs2),
      .rd       (id_rd),
      .busy     (sb_busy),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy),
      .rd_busy  (rd_busy)
   );

   // ex_rd != 0 already guarantees a matching source is not x0.
   assign load_use   = ex_valid && (ex_opcode == LOAD) && (ex_rd != 5'd0) &&
                       ((use1 && id_rs1 == ex_rd) || (use2 && id_rs2 == ex_rd));
   assign raw        = (use1 && rs1_busy) || (use2 && rs2_busy);
   assign waw        = rd_busy;
   assign structural = md_op && (state != MD_IDLE);
   assign stall      = !rst && id_valid && (load_use || raw || waw || structural);

   // A redirect squashes the ID instruction, so it overrides any stall.
   assign pc_stall    = stall && !br_taken;
   assign ifid_stall  = pc_stall;
   assign ifid_flush  = !rst && br_taken;
   assign idex_bubble = stall || ifid_flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= MD_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      md_start    = 1'b0;
      md_wb_grant = 1'b0;
      case (state)
         MD_IDLE: begin
            md_start = !rst && id_valid && md_op && !stall && !br_taken;
            if (md_start)
               state_nx = MD_BUSY;
         end
         MD_BUSY: begin
            if (md_done)
               state_nx = MD_PEND;
         end
         MD_PEND: begin
            // Pipeline writeback always owns the port when it wants it.
            md_wb_grant = !rst && !wb_wen;
            if (md_wb_grant)
               state_nx = MD_IDLE;
         end
         default: state_nx = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         md_rd <= 5'd0;
      else if (md_start)
         md_rd <= id_rd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (pc_stall && stall_cnt != {CNT_W{1'b1}})
         stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a behavioural model of the hazard rules.
module tb_id_hazard_ctrl;

   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_BRANCH = 7'b1100011;
   localparam logic [6:0] T_JAL = 7'b1101111, T_JALR = 7'b1100111, T_LUI = 7'b0110111;
   localparam logic [6:0] T_AUIPC = 7'b0010111, T_OP = 7'b0110011, T_OP32 = 7'b0111011;
   localparam logic [6:0] T_OPIMM = 7'b0010011, T_SYS = 7'b1110011;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          id_valid = 1'b0;
   logic [6:0]    id_opcode = 7'd0;
   logic [6:0]    id_func7 = 7'd0;
   logic [4:0]    id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
   logic          ex_valid = 1'b0;
   logic [6:0]    ex_opcode = 7'd0;
   logic [4:0]    ex_rd = 5'd0;
   logic          br_taken = 1'b0, wb_wen = 1'b0, md_done = 1'b0;
   logic          pc_stall, ifid_stall, ifid_flush, idex_bubble, md_start, md_wb_grant;
   logic [4:0]    md_rd;
   logic [31:0]   sb_busy;
   logic [CW-1:0] stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   id_hazard_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_func7(id_func7),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_valid(ex_valid),
      .ex_opcode(ex_opcode), .ex_rd(ex_rd), .br_taken(br_taken), .wb_wen(wb_wen),
      .md_done(md_done), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .md_start(md_start),
      .md_wb_grant(md_wb_grant), .md_rd(md_rd), .sb_busy(sb_busy), .stall_cnt(stall_cnt)
   );

   // clock/reset block
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: pending-write set, one in-flight MD op, saturating counter
   bit m_busy[32];
   bit m_inflight, m_ready;
   logic [4:0] m_rd;
   int m_cnt;

   function automatic bit reads_rs1(input logic [6:0] op);
      return !(op inside {T_LUI, T_AUIPC, T_JAL});
   endfunction

   function automatic bit reads_rs2(input logic [6:0] op);
      return op inside {T_OP, T_OP32, T_STORE, T_BRANCH};
   endfunction

   always @(negedge clk) begin
      bit u1, u2, md, lu, raw, waw, st, stl, e_pc, e_start, e_grant;
      logic [31:0] busy_vec;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         m_inflight = 1'b0; m_ready = 1'b0; m_rd = 5'd0; m_cnt = 0;
         e_pc = 0; e_start = 0; e_grant = 0; stl = 0;
      end else begin
         u1  = reads_rs1(id_opcode);
         u2  = reads_rs2(id_opcode);
         md  = (id_opcode == T_OP || id_opcode == T_OP32) && id_func7 == 7'd1;
         lu  = ex_valid && ex_opcode == T_LOAD && ex_rd != 0 &&
               ((u1 && id_rs1 == ex_rd) || (u2 && id_rs2 == ex_rd));
         raw = (u1 && id_rs1 != 0 && m_busy[id_rs1]) || (u2 && id_rs2 != 0 && m_busy[id_rs2]);
         waw = id_rd != 0 && m_busy[id_rd];
         st  = md && m_inflight;
         stl = id_valid && (lu || raw || waw || st);
         e_pc    = stl && !br_taken;
         e_start = !m_inflight && id_valid && md && !stl && !br_taken;
         e_grant = m_inflight && m_ready && !wb_wen;
      end
      busy_vec = '0;
      for (int i = 0; i < 32; i++) busy_vec[i] = m_busy[i];
      chk("pc_stall", {31'd0, pc_stall}, {31'd0, e_pc});
      chk("ifid_stall", {31'd0, ifid_stall}, {31'd0, e_pc});
      chk("ifid_flush", {31'd0, ifid_flush}, {31'd0, br_taken && !rst});
      chk("idex_bubble", {31'd0, idex_bubble}, {31'd0, stl || (br_taken && !rst)});
      chk("md_start", {31'd0, md_start}, {31'd0, e_start});
      chk("md_wb_grant", {31'd0, md_wb_grant}, {31'd0, e_grant});
      chk("md_rd", {27'd0, md_rd}, {27'd0, m_rd});
      chk("sb_busy", sb_busy, busy_vec);
      chk("stall_cnt", {28'd0, stall_cnt}, m_cnt);
      if (!rst) begin
         if (e_grant) begin
            m_busy[m_rd] = 1'b0; m_inflight = 1'b0; m_ready = 1'b0;
         end else if (m_inflight && !m_ready && md_done) begin
            m_ready = 1'b1;
         end
         if (e_start) begin
            m_inflight = 1'b1; m_ready = 1'b0; m_rd = id_rd;
            if (id_rd != 0) m_busy[id_rd] = 1'b1;
         end
         if (e_pc && m_cnt < CMAX) m_cnt++;
      end
   end

   // driver tasks
   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   task automatic set_id(input logic v, input logic [6:0] op, input logic [6:0] f7,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      id_valid = v; id_opcode = op; id_func7 = f7; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
   endtask

   task automatic set_ex(input logic v, input logic [6:0] op, input logic [4:0] rd);
      ex_valid = v; ex_opcode = op; ex_rd = rd;
   endtask

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 5))
         0: return 5'd0;
         1: return 5'd1;
         2: return 5'd2;
         3: return 5'd3;
         4: return 5'd5;
         default: return 5'd10;
      endcase
   endfunction

   initial begin
      logic [6:0] ops [11];
      ops = '{T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_LUI, T_AUIPC, T_OP, T_OP32, T_OPIMM, T_SYS};

      // reset: outputs forced low even with a redirect and an MD op presented
      nxt(); nxt();
      br_taken = 1'b1; set_id(1, T_OP, 7'd1, 1, 2, 10);
      settle();
      chk("rst_flush", {31'd0, ifid_flush}, 0);
      chk("rst_start", {31'd0, md_start}, 0);
      chk("rst_busy", sb_busy, 0);
      chk("rst_cnt", {28'd0, stall_cnt}, 0);
      chk("rst_md_rd", {27'd0, md_rd}, 0);
      nxt();
      rst = 1'b0; br_taken = 1'b0;

      // load-use: ld x5 in EX, add x6,x5,x7 in ID
      set_ex(1, T_LOAD, 5); set_id(1, T_OP, 7'd0, 5, 7, 6);
      settle();
      chk("lu_pc_stall", {31'd0, pc_stall}, 1);
      chk("lu_ifid_stall", {31'd0, ifid_stall}, 1);
      chk("lu_bubble", {31'd0, idex_bubble}, 1);
      nxt();
      set_ex(0, T_OPIMM, 0);
      settle();
      chk("lu_release", {31'd0, pc_stall}, 0);
      chk("lu_cnt", {28'd0, stall_cnt}, 1);
      nxt();
      set_ex(1, T_LOAD, 0); set_id(1, T_OP, 7'd0, 0, 0, 6);
      settle();
      chk("lu_x0", {31'd0, pc_stall}, 0);
      nxt();

      // MD chain: mul x10,x1,x2 then add x11,x10,x3
      set_ex(0, T_OPIMM, 0); set_id(1, T_OP, 7'd1, 1, 2, 10);
      settle();
      chk("mc_start", {31'd0, md_start}, 1);
      nxt();
      set_id(1, T_OP, 7'd0, 10, 3, 11);
      settle();
      chk("mc_start_pulse", {31'd0, md_start}, 0);
      chk("mc_busy", sb_busy, 32'h400);
      chk("mc_raw", {31'd0, pc_stall}, 1);
      nxt();
      md_done = 1'b1;
      settle();
      chk("mc_done_stall", {31'd0, pc_stall}, 1);
      chk("mc_no_grant_yet", {31'd0, md_wb_grant}, 0);
      nxt();
      md_done = 1'b0; wb_wen = 1'b0;
      settle();
      chk("mc_grant", {31'd0, md_wb_grant}, 1);
      chk("mc_md_rd", {27'd0, md_rd}, 10);
      chk("mc_grant_stall", {31'd0, pc_stall}, 1);
      nxt();
      settle();
      chk("mc_release", {31'd0, pc_stall}, 0);
      chk("mc_busy_clr", sb_busy, 0);
      chk("mc_cnt", {28'd0, stall_cnt}, 4);
      nxt();

      // structural, WAW, then port contention
      set_id(1, T_OP, 7'd1, 1, 2, 10);
      settle();
      chk("pc_start", {31'd0, md_start}, 1);
      nxt();
      set_id(1, T_OP, 7'd1, 1, 2, 12);
      settle();
      chk("struct_stall", {31'd0, pc_stall}, 1);
      chk("struct_no_start", {31'd0, md_start}, 0);
      nxt();
      set_id(1, T_OPIMM, 7'd0, 0, 1, 10); md_done = 1'b1;
      settle();
      chk("waw_stall", {31'd0, pc_stall}, 1);
      nxt();
      md_done = 1'b0; id_valid = 1'b0; wb_wen = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("port_wb_wins", {31'd0, md_wb_grant}, 0);
         chk("port_busy_held", sb_busy, 32'h400);
         nxt();
      end
      wb_wen = 1'b0;
      settle();
      chk("port_grant", {31'd0, md_wb_grant}, 1);
      nxt();
      settle();
      chk("port_busy_clr", sb_busy, 0);
      chk("port_cnt", {28'd0, stall_cnt}, 6);
      nxt();

      // redirect beats load-use and MD launch
      set_ex(1, T_LOAD, 5); set_id(1, T_OP, 7'd1, 5, 1, 7); br_taken = 1'b1;
      settle();
      chk("br_flush", {31'd0, ifid_flush}, 1);
      chk("br_bubble", {31'd0, idex_bubble}, 1);
      chk("br_pc_stall", {31'd0, pc_stall}, 0);
      chk("br_md_start", {31'd0, md_start}, 0);
      nxt();
      br_taken = 1'b0; id_valid = 1'b0; set_ex(0, T_OPIMM, 0);
      settle();
      chk("br_cnt", {28'd0, stall_cnt}, 6);
      nxt();

      // reset in BUSY abandons the MD result
      set_id(1, T_OP, 7'd1, 1, 2, 10);
      settle();
      chk("rb_start", {31'd0, md_start}, 1);
      nxt();
      id_valid = 1'b0;
      settle();
      chk("rb_busy", sb_busy, 32'h400);
      nxt();
      rst = 1'b1;
      #1;
      chk("rb_async_busy", sb_busy, 0);
      chk("rb_async_cnt", {28'd0, stall_cnt}, 0);
      nxt();
      rst = 1'b0; md_done = 1'b1;
      settle();
      chk("rb_done_ignored", {31'd0, md_wb_grant}, 0);
      nxt();
      md_done = 1'b0;
      settle();
      chk("rb_no_grant", {31'd0, md_wb_grant}, 0);
      nxt();
      set_id(1, T_OP32, 7'd1, 3, 2, 5);
      settle();
      chk("rb_idle_start", {31'd0, md_start}, 1);
      nxt();

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         logic [6:0] op;
         op = ops[$urandom_range(0, 10)];
         rst = ($urandom_range(0, 199) == 0);
         set_id($urandom_range(0, 9) < 8, op,
                (op == T_OP || op == T_OP32) ? (($urandom_range(0, 1) == 1) ? 7'd1 : 7'd0) : 7'h20,
                pick_reg(), pick_reg(), pick_reg());
         set_ex($urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? T_LOAD : T_OP, pick_reg());
         br_taken = ($urandom_range(0, 9) == 0);
         wb_wen   = ($urandom_range(0, 9) < 4);
         md_done  = ($urandom_range(0, 3) == 0);
         nxt();
      end
      rst = 1'b0;
      nxt();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      n_errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
